// File: rtl/jt89x.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : jt89x                                                           |
// | Purpose  : SN76489-style PSG: three square-wave tones, one LFSR noise       |
// |            channel, mono mix and optional stereo panning                   |
// |            (enabled by defining JT89X_STEREO_EN).                          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module jt89x #(
    parameter int TW  = 10,
    parameter int OW  = 10,
    parameter int DIV = 16,
    parameter int NW  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clken,
    input  logic                 wr_n,
    input  logic [7:0]           din,
    input  logic                 stereo_wr,
    output logic signed [OW-1:0] ch0,
    output logic signed [OW-1:0] ch1,
    output logic signed [OW-1:0] ch2,
    output logic signed [OW-1:0] noise,
    output logic signed [OW+1:0] sound,
    output logic signed [OW+1:0] left,
    output logic signed [OW+1:0] right
);

    localparam int              c_pw   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0]   c_one  = TW'(1);
    localparam logic [NW-1:0]   c_seed = {1'b1, {(NW-1){1'b0}}};

    logic                 r_wr_n;
    logic                 w_wr_en;
    logic [2:0]           r_latch;
    logic [TW-1:0]        r_tone [0:2];
    logic [3:0]           r_vol  [0:3];
    logic [2:0]           r_ctrl3;
    logic                 r_nrst;
    logic [c_pw-1:0]      r_pre;
    logic                 w_tick;
    logic [TW-1:0]        r_cnt  [0:2];
    logic [2:0]           r_f;
    logic [2:0]           w_f_next;
    logic [5:0]           r_ndiv;
    logic [5:0]           w_ndiv_next;
    logic [5:0]           w_nlast;
    logic                 r_fnz;
    logic                 w_fnz_next;
    logic                 w_fb;
    logic [NW-1:0]        r_lfsr;
    logic [NW-1:0]        w_lfsr_next;
    logic signed [OW-1:0] r_ch   [0:3];
    logic signed [OW+1:0] w_sound;

    function automatic logic signed [OW-1:0] amp(input logic [3:0] v, input logic pos);
        logic [9:0]    a;
        logic [OW-1:0] s;
        case (v)
            4'd0:    a = 10'd511;
            4'd1:    a = 10'd406;
            4'd2:    a = 10'd322;
            4'd3:    a = 10'd256;
            4'd4:    a = 10'd203;
            4'd5:    a = 10'd161;
            4'd6:    a = 10'd128;
            4'd7:    a = 10'd102;
            4'd8:    a = 10'd81;
            4'd9:    a = 10'd64;
            4'd10:   a = 10'd51;
            4'd11:   a = 10'd40;
            4'd12:   a = 10'd32;
            4'd13:   a = 10'd26;
            4'd14:   a = 10'd20;
            default: a = 10'd0;
        endcase
        s = OW'(a >> (10 - OW));
        return pos ? $signed(s) : -$signed(s);
    endfunction

    function automatic logic signed [OW+1:0] sext(input logic signed [OW-1:0] x);
        return {{2{x[OW-1]}}, x};
    endfunction

    // A write is taken only on the falling edge of wr_n, whatever clken does.
    assign w_wr_en = ~wr_n & r_wr_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_n  <= 1'b1;
            r_latch <= 3'b000;
            r_ctrl3 <= 3'b100;
            r_nrst  <= 1'b0;
            for (int n = 0; n < 3; n++) r_tone[n] <= '0;
            for (int n = 0; n < 4; n++) r_vol[n] <= 4'hF;
        end else begin
            r_wr_n <= wr_n;
            r_nrst <= 1'b0;
            if (w_wr_en) begin
                if (din[7]) begin
                    r_latch <= din[6:4];
                    if (din[4]) begin
                        r_vol[din[6:5]] <= din[3:0];
                    end else begin
                        case (din[6:5])
                            2'b00:   r_tone[0][3:0] <= din[3:0];
                            2'b01:   r_tone[1][3:0] <= din[3:0];
                            2'b10:   r_tone[2][3:0] <= din[3:0];
                            default: begin
                                r_ctrl3 <= din[2:0];
                                r_nrst  <= 1'b1;
                            end
                        endcase
                    end
                end else if (r_latch[0]) begin
                    r_vol[r_latch[2:1]] <= din[3:0];
                end else begin
                    case (r_latch[2:1])
                        2'b00:   r_tone[0][TW-1:4] <= din[TW-5:0];
                        2'b01:   r_tone[1][TW-1:4] <= din[TW-5:0];
                        2'b10:   r_tone[2][TW-1:4] <= din[TW-5:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    assign w_tick = clken && (r_pre == c_pw'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)        r_pre <= '0;
        else if (clken) r_pre <= w_tick ? '0 : r_pre + 1'b1;
    end

    // Periods 0 and 1 pin the flip-flop high so the channel acts as a DC level.
    always_comb begin
        w_f_next = r_f;
        for (int n = 0; n < 3; n++) begin
            if (r_tone[n] <= c_one)     w_f_next[n] = 1'b1;
            else if (r_cnt[n] <= c_one) w_f_next[n] = ~r_f[n];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 3; n++) r_cnt[n] <= '0;
            r_f <= '0;
        end else if (w_tick) begin
            for (int n = 0; n < 3; n++)
                r_cnt[n] <= (r_cnt[n] <= c_one) ? r_tone[n] : r_cnt[n] - 1'b1;
            r_f <= w_f_next;
        end
    end

    always_comb begin
        case (r_ctrl3[1:0])
            2'b00:   w_nlast = 6'd15;
            2'b01:   w_nlast = 6'd31;
            default: w_nlast = 6'd63;
        endcase
        w_fnz_next  = r_fnz;
        w_ndiv_next = r_ndiv;
        if (r_ctrl3[1:0] == 2'b11) begin
            w_fnz_next = w_f_next[2];
        end else if (r_ndiv >= w_nlast) begin
            w_ndiv_next = '0;
            w_fnz_next  = ~r_fnz;
        end else begin
            w_ndiv_next = r_ndiv + 1'b1;
        end
        w_fb        = r_ctrl3[2] ? (r_lfsr[0] ^ r_lfsr[3]) : r_lfsr[0];
        w_lfsr_next = r_lfsr;
        if (w_tick && w_fnz_next && !r_fnz)
            w_lfsr_next = (r_lfsr == '0) ? c_seed : {w_fb, r_lfsr[NW-1:1]};
        // A noise-control write reseeds one cycle later, overriding any shift.
        if (r_nrst)
            w_lfsr_next = c_seed;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ndiv <= '0;
            r_fnz  <= 1'b0;
            r_lfsr <= c_seed;
        end else begin
            r_lfsr <= w_lfsr_next;
            if (w_tick) begin
                r_ndiv <= w_ndiv_next;
                r_fnz  <= w_fnz_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) r_ch[n] <= '0;
        end else if (w_tick) begin
            for (int n = 0; n < 3; n++) r_ch[n] <= amp(r_vol[n], w_f_next[n]);
            r_ch[3] <= amp(r_vol[3], w_lfsr_next[0]);
        end
    end

    assign ch0     = r_ch[0];
    assign ch1     = r_ch[1];
    assign ch2     = r_ch[2];
    assign noise   = r_ch[3];
    assign w_sound = sext(r_ch[0]) + sext(r_ch[1]) + sext(r_ch[2]) + sext(r_ch[3]);
    assign sound   = w_sound;

`ifdef JT89X_STEREO_EN
    logic [7:0]           r_pan;
    logic signed [OW+1:0] w_left;
    logic signed [OW+1:0] w_right;

    always_ff @(posedge clk) begin
        if (rst)            r_pan <= 8'hFF;
        else if (stereo_wr) r_pan <= din;
    end

    always_comb begin
        w_left  = '0;
        w_right = '0;
        for (int n = 0; n < 4; n++) begin
            if (r_pan[4+n]) w_left  = w_left  + sext(r_ch[n]);
            if (r_pan[n])   w_right = w_right + sext(r_ch[n]);
        end
    end

    assign left  = w_left;
    assign right = w_right;
`else
    logic w_unused;
    assign w_unused = stereo_wr;
    assign left     = w_sound;
    assign right    = w_sound;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jt89x.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_jt89x                                                        |
// | Purpose  : Self-checking bench for jt89x against a cycle-level model.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_jt89x;

    localparam int TW     = 10;
    localparam int OW     = 10;
    localparam int DIV    = 16;
    localparam int NW     = 16;
    localparam int c_seed = 1 << (NW - 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 clken;
    logic                 wr_n;
    logic [7:0]           din;
    logic                 stereo_wr;
    logic signed [OW-1:0] ch0, ch1, ch2, noise;
    logic signed [OW+1:0] sound, left, right;

    always #5 clk = ~clk;

    jt89x #(.TW(TW), .OW(OW), .DIV(DIV), .NW(NW)) u_dut (
        .clk(clk), .rst(rst), .clken(clken), .wr_n(wr_n), .din(din),
        .stereo_wr(stereo_wr), .ch0(ch0), .ch1(ch1), .ch2(ch2), .noise(noise),
        .sound(sound), .left(left), .right(right)
    );

    int checks   = 0;
    int failures = 0;
    int amp_tab [16] = '{511, 406, 322, 256, 203, 161, 128, 102, 81, 64, 51, 40, 32, 26, 20, 0};

    // Reference model state: what the chip should hold after each clock edge.
    int m_wrq, m_latch, m_ctrl3, m_pan, m_pre, m_ndiv, m_fnz, m_nrst, m_lfsr, m_shift_cnt;
    int m_tone [3];
    int m_vol  [4];
    int m_cnt  [3];
    int m_f    [3];
    int e_ch   [4];
    bit m_shifted;
    bit m_check;

    typedef struct {
        logic [7:0] d;
        int         ch;
        int         exp;
    } vec_t;
    vec_t tbl [10];

    function automatic int amp(int v);
        return amp_tab[v] >> (10 - OW);
    endfunction

    function automatic int lfsr_step(int s, int white);
        int fb;
        if (s == 0) return c_seed;
        fb = white ? ((s ^ (s >> 3)) & 1) : (s & 1);
        return (s >> 1) | (fb << (NW - 1));
    endfunction

    function automatic logic signed [31:0] chan(int c);
        case (c)
            0:       return ch0;
            1:       return ch1;
            2:       return ch2;
            default: return noise;
        endcase
    endfunction

    task automatic model_edge();
        int d, acc, tick, fnz_new, lfsr_new, nrst_new;
        int f_new [3];
        d = din;
        m_shifted = 0;
        if (rst) begin
            m_wrq = 1; m_latch = 0; m_ctrl3 = 4; m_pan = 255; m_pre = 0;
            m_ndiv = 0; m_fnz = 0; m_nrst = 0; m_lfsr = c_seed;
            for (int n = 0; n < 3; n++) begin m_tone[n] = 0; m_cnt[n] = 0; m_f[n] = 0; end
            for (int n = 0; n < 4; n++) begin m_vol[n] = 15; e_ch[n] = 0; end
            return;
        end
        acc  = (wr_n == 1'b0) && (m_wrq == 1);
        tick = clken && (m_pre == DIV - 1);
        if (clken) m_pre = (m_pre + 1) % DIV;
        lfsr_new = m_lfsr;
        if (tick) begin
            for (int n = 0; n < 3; n++) begin
                f_new[n] = m_f[n];
                if (m_cnt[n] <= 1) begin m_cnt[n] = m_tone[n]; f_new[n] = !m_f[n]; end
                else m_cnt[n] = m_cnt[n] - 1;
                if (m_tone[n] <= 1) f_new[n] = 1;
            end
            if ((m_ctrl3 & 3) == 3) fnz_new = f_new[2];
            else begin
                m_ndiv = m_ndiv + 1;
                if (m_ndiv >= (16 << (m_ctrl3 & 3))) begin m_ndiv = 0; fnz_new = !m_fnz; end
                else fnz_new = m_fnz;
            end
            if (fnz_new && !m_fnz) begin
                lfsr_new  = lfsr_step(m_lfsr, (m_ctrl3 >> 2) & 1);
                m_shifted = 1;
            end
            m_fnz = fnz_new;
            for (int n = 0; n < 3; n++) m_f[n] = f_new[n];
        end
        if (m_nrst) begin lfsr_new = c_seed; m_shifted = 0; m_shift_cnt = 0; end
        else if (m_shifted) m_shift_cnt++;
        m_lfsr = lfsr_new;
        if (tick) begin
            for (int n = 0; n < 3; n++) e_ch[n] = m_f[n] ? amp(m_vol[n]) : -amp(m_vol[n]);
            e_ch[3] = (m_lfsr & 1) ? amp(m_vol[3]) : -amp(m_vol[3]);
        end
        nrst_new = 0;
        if (acc) begin
            if (d & 128) begin
                m_latch = (d >> 4) & 7;
                if (m_latch & 1) m_vol[m_latch >> 1] = d & 15;
                else if (m_latch == 6) begin m_ctrl3 = d & 7; nrst_new = 1; end
                else m_tone[m_latch >> 1] = (m_tone[m_latch >> 1] & ~15) | (d & 15);
            end else begin
                if (m_latch & 1) m_vol[m_latch >> 1] = d & 15;
                else if (m_latch != 6)
                    m_tone[m_latch >> 1] = (m_tone[m_latch >> 1] & 15) | ((d & ((1 << (TW - 4)) - 1)) << 4);
            end
        end
        m_nrst = nrst_new;
        m_wrq  = wr_n;
        if (stereo_wr) m_pan = d;
    endtask

    task automatic check_outputs();
        int es, el, er;
        es = e_ch[0] + e_ch[1] + e_ch[2] + e_ch[3];
`ifdef JT89X_STEREO_EN
        el = 0; er = 0;
        for (int n = 0; n < 4; n++) begin
            if ((m_pan >> (4 + n)) & 1) el += e_ch[n];
            if ((m_pan >> n) & 1)       er += e_ch[n];
        end
`else
        el = es; er = es;
`endif
        checks++;
        if (ch0 !== e_ch[0] || ch1 !== e_ch[1] || ch2 !== e_ch[2] || noise !== e_ch[3] ||
            sound !== es || left !== el || right !== er) begin
            failures++;
            $display("FAIL lockstep t=%0t got ch=%0d,%0d,%0d,%0d snd=%0d l=%0d r=%0d want ch=%0d,%0d,%0d,%0d snd=%0d l=%0d r=%0d",
                     $time, ch0, ch1, ch2, noise, sound, left, right,
                     e_ch[0], e_ch[1], e_ch[2], e_ch[3], es, el, er);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        if (m_check) check_outputs();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write(logic [7:0] d);
        din = d; wr_n = 1'b0; step();
        wr_n = 1'b1; step();
    endtask

    task automatic chk(string name, logic signed [31:0] act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic signed [31:0] prev;
        int cnt, bound, s;
        int rb [21];

        tbl[0] = '{8'h90, 0, 511};
        tbl[1] = '{8'h93, 0, 256};
        tbl[2] = '{8'h9D, 0, 26};
        tbl[3] = '{8'hB6, 1, 128};
        tbl[4] = '{8'h0C, 1, 32};
        tbl[5] = '{8'hBA, 1, 51};
        tbl[6] = '{8'hD8, 2, 81};
        tbl[7] = '{8'hDE, 2, 20};
        tbl[8] = '{8'hDF, 2, 0};
        tbl[9] = '{8'hB1, 1, 406};

        rst = 1'b1; clken = 1'b1; wr_n = 1'b1; din = 8'h00; stereo_wr = 1'b0;
        m_check = 1'b0; m_shift_cnt = 0;
        step();
        m_check = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_ch0", ch0, 0);   chk("rst_ch1", ch1, 0);   chk("rst_ch2", ch2, 0);
        chk("rst_noise", noise, 0); chk("rst_sound", sound, 0);
        chk("rst_left", left, 0); chk("rst_right", right, 0);

        idle(1000);
        chk("idle_sound", sound, 0); chk("idle_left", left, 0); chk("idle_right", right, 0);

        // Square wave: tone0 = 5, full volume.
        write(8'h85); write(8'h00); write(8'h90);
        prev = ch0;
        for (int k = 0; k < 5; k++) begin
            cnt = 0;
            while (ch0 === prev && cnt < 400) begin step(); cnt++; end
            if (cnt >= 400) begin
                chk("sq_edge_timeout", cnt, 0);
                break;
            end
            if (k >= 2) begin
                chk("sq_half_period", cnt, 5 * DIV);
                chk("sq_level", ch0, -prev);
            end
            prev = ch0;
        end
        chk("sq_amp", (ch0 < 0) ? -ch0 : ch0, 511);

        // Period 1 gives a DC level; silencing takes effect at the next tick.
        write(8'h81); write(8'h00); write(8'h90);
        idle(40);  chk("dc_level", ch0, 511);
        idle(100); chk("dc_hold", ch0, 511);
        write(8'h9F); idle(DIV);
        chk("dc_silence", ch0, 0);

        write(8'hA1); write(8'h00); write(8'hC1); write(8'h00);
        for (int i = 0; i < 10; i++) begin
            write(tbl[i].d);
            idle(DIV + 2);
            chk("vol_table", chan(tbl[i].ch), tbl[i].exp);
        end
        write(8'hBF); write(8'hDF);

        // Long wr_n low: only the first byte may be taken.
        write(8'h90); idle(20);
        chk("hold_pre", ch0, 511);
        din = 8'h9F; wr_n = 1'b0; step();
        din = 8'h90; idle(9);
        wr_n = 1'b1; step(); idle(20);
        chk("hold_one_write", ch0, 0);

        // Reset arriving together with a write discards the write.
        write(8'h90); idle(20);
        chk("rst_wr_pre", ch0, 511);
        rst = 1'b1; wr_n = 1'b0; din = 8'h93; step();
        rst = 1'b0; wr_n = 1'b1; step(); idle(20);
        chk("rst_wr_discard", ch0, 0);

        // White noise from the reload seed, then a restart.
        s = c_seed;
        for (int k = 1; k <= 20; k++) begin s = lfsr_step(s, 1); rb[k] = s & 1; end
        write(8'hE4); write(8'hF0); idle(20);
        bound = 0;
        while (m_shift_cnt < 20 && bound < 20 * 40 * DIV) begin
            step(); bound++;
            if (m_shifted) chk("noise_seq", noise, rb[m_shift_cnt] ? 511 : -511);
        end
        if (bound >= 20 * 40 * DIV) chk("noise_timeout", bound, 0);
        write(8'hE4); idle(DIV + 2);
        bound = 0;
        while (m_shift_cnt < 3 && bound < 4 * 40 * DIV) begin
            step(); bound++;
            if (m_shifted) chk("noise_restart", noise, rb[m_shift_cnt] ? 511 : -511);
        end
        if (bound >= 4 * 40 * DIV) chk("noise_restart_timeout", bound, 0);

`ifdef JT89X_STEREO_EN
        rst = 1'b1; step(); rst = 1'b0;
        din = 8'h1E; stereo_wr = 1'b1; step(); stereo_wr = 1'b0;
        write(8'h90); write(8'hB0); write(8'hD0); write(8'hF0);
        idle(DIV + 4);
        chk("pan_left", left, 511);
        chk("pan_right", right, e_ch[1] + e_ch[2] + e_ch[3]);
`endif

        for (int i = 0; i < 15000 && failures < 40; i++) begin
            clken     = ($urandom_range(0, 4) != 0);
            wr_n      = ($urandom_range(0, 5) != 0);
            din       = 8'($urandom);
            stereo_wr = ($urandom_range(0, 15) == 0);
            rst       = (i == 7000);
            step();
        end
        rst = 1'b0; wr_n = 1'b1; stereo_wr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jt89x.md
JT89X -- requirements
Module: jt89x

Interface
REQ-001 Parameter TW, default 10, tone period width; legal range 5..10.
REQ-002 Parameter OW, default 10, per-channel signed output width; legal range 6..10.
REQ-003 Parameter DIV, default 16, clken pulses per tone tick; legal range 1..256.
REQ-004 Parameter NW, default 16, noise LFSR width; legal range 4..16.
REQ-005 Ports: clk input 1, clock; rst input 1, reset, synchronous, active-high.
REQ-006 clken input 1: clock enable; all state except the write interface advances only when high.
REQ-007 wr_n input 1: write strobe, active low.
REQ-008 din input 8: register write data.
REQ-009 stereo_wr input 1: one-cycle pan register write strobe, sampled every clk.
REQ-010 ch0, ch1, ch2, noise outputs OW signed: per-channel audio.
REQ-011 sound output OW+2 signed: mono mix.
REQ-012 left, right outputs OW+2 signed: stereo mixes.

Function
REQ-013 Write detect: wr_n is registered each clk; one write is accepted on the cycle where wr_n=0 and its registered value=1, independent of clken.
REQ-014 Latch byte (din[7]=1): latch<=din[6:4]; latch 000/010/100 -> tone0/1/2[3:0]<=din[3:0]; 110 -> ctrl3<=din[2:0]; odd latch -> vol0..vol3<=din[3:0].
REQ-015 Data byte (din[7]=0): latched tone n -> tone n[TW-1:4]<=din[TW-5:0]; latched volume -> that volume<=din[3:0]; latch 110 -> ignored.
REQ-016 Any accepted write with latch 110 (latch byte only) reloads the LFSR to 1<<(NW-1) on the next cycle.
REQ-017 Prescaler: counter 0..DIV-1 advances on clken; tick = clken high with counter=DIV-1; wraps to 0.
REQ-018 Tone n: TW-bit down counter; on tick, if counter<=1 it reloads tone n and toggles flip-flop f n, else decrements.
REQ-019 Tone period 0 or 1: f n held at 1, output is constant +amplitude.
REQ-020 Tone output = f n ? +amp(vol n) : -amp(vol n).
REQ-021 Noise clock: ctrl3[1:0]=00/01/10 -> internal divider with period 16/32/64 ticks toggling fnz; 11 -> fnz follows f2.
REQ-022 LFSR shifts right once per fnz rising edge; feedback into bit NW-1 = bit0 XOR bit3 when ctrl3[2]=1 (white), bit0 when 0 (periodic).
REQ-023 LFSR all-zero state is replaced by 1<<(NW-1) on the same shift.
REQ-024 Noise output = LFSR bit0 ? +amp(vol3) : -amp(vol3).
REQ-025 amp(v), 2 dB steps, v=0..15: 511,406,322,256,203,161,128,102,81,64,51,40,32,26,20,0, right-shifted by 10-OW.
REQ-026 Channel outputs are registered, updated one clk after the tick that changes them.
REQ-027 sound = sign-extended sum of ch0+ch1+ch2+noise, combinational from the registered channels, no saturation.
REQ-028 Simultaneous write and tick: the tick uses the pre-write register values; the new value takes effect from the next tick.

Reset
REQ-029 rst clears: prescaler, tone counters, noise divider, all f flip-flops, latch=000, and tone0..2=0.
REQ-030 rst sets: vol0..vol3=15, ctrl3=100, LFSR=1<<(NW-1), pan=8'hFF, and the registered wr_n=1.
REQ-031 All audio outputs are 0 in the cycle after rst; rst mid-write discards that write.

Configuration
REQ-032 Macro JT89X_STEREO_EN defined: stereo_wr loads pan<=din; left sums channels enabled by pan[7:4] (bit4=ch0, bit5=ch1, bit6=ch2, bit7=noise); right uses pan[3:0] in the same order; disabled channels contribute 0.
REQ-033 Macro JT89X_STEREO_EN undefined: no pan register exists, stereo_wr is ignored, and left=right=sound.

Verification
REQ-034 Reset, then idle 1000 clk with clken=1 -> all outputs 0.
REQ-035 Write 8'h85, 8'h00, 8'h90 (DIV=16) -> ch0=+511/-511 square, each half-period 5*16 clken pulses.
REQ-036 Write tone0=1, vol0=0 -> ch0 constant +511; write vol0=15 -> ch0=0 one tick later.
REQ-037 Write 8'hE4, 8'hF0 -> white noise starting from the reload seed; first 20 LFSR values match a reference model; rewrite 8'hE4 -> sequence restarts.
REQ-038 Hold wr_n low for 10 clk with 8'h9F -> exactly one write accepted.
REQ-039 With JT89X_STEREO_EN defined and pan=8'h1E at full volume -> left=ch0 only, right=ch1+ch2+noise.
